// File: rtl/pong_frame_sequencer_pkg.sv
// Shared definitions for the Pong frame sequencer: FSM state encodings, update-task
// indices and the one-hot TaskStart patterns for each task.
package pong_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_e;

    typedef logic [1:0] task_idx_t;

    localparam task_idx_t TASK_PADDLE  = 2'd0;
    localparam task_idx_t TASK_BALL    = 2'd1;
    localparam task_idx_t TASK_COLLIDE = 2'd2;
    localparam task_idx_t TASK_SCORE   = 2'd3;

    localparam logic [3:0] START_PADDLE  = 4'b0001;
    localparam logic [3:0] START_BALL    = 4'b0010;
    localparam logic [3:0] START_COLLIDE = 4'b0100;
    localparam logic [3:0] START_SCORE   = 4'b1000;

    function automatic logic [3:0] task_onehot(input task_idx_t idx);
        case (idx)
            TASK_PADDLE:  return START_PADDLE;
            TASK_BALL:    return START_BALL;
            TASK_COLLIDE: return START_COLLIDE;
            default:      return START_SCORE;
        endcase
    endfunction

endpackage

// File: rtl/pong_frame_sequencer_vblank_detector.sv
// Detects the first line of each vertical blanking interval and divides those events
// down to a one-cycle launch pulse every (frame_div+1) intervals.
module pong_frame_sequencer_vblank_detector #(
    parameter int ResolutionSize = 10,
    parameter int FrameDivSize   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ResolutionSize-1:0] ypos,
    input  logic [ResolutionSize-1:0] yresolution,
    input  logic [FrameDivSize-1:0]   frame_div,
    output logic                      launch
);

    logic                    in_blank;
    logic                    blank_start;
    logic                    in_blank_dly_q, in_blank_dly_d;
    logic [FrameDivSize-1:0] divider_q, divider_d;
    logic                    launch_q, launch_d;

    // Divider advances on every blanking edge regardless of sequencer state; a divider
    // left above a newly lowered frame_div simply wraps around before matching.
    always_comb begin
        in_blank       = (ypos >= yresolution);
        blank_start    = in_blank & ~in_blank_dly_q;
        in_blank_dly_d = in_blank;
        divider_d      = divider_q;
        launch_d       = 1'b0;
        if (blank_start) begin
            if (divider_q == frame_div) begin
                divider_d = '0;
                launch_d  = 1'b1;
            end else begin
                divider_d = divider_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_blank_dly_q <= 1'b0;
            divider_q      <= '0;
            launch_q       <= 1'b0;
        end else begin
            in_blank_dly_q <= in_blank_dly_d;
            divider_q      <= divider_d;
            launch_q       <= launch_d;
        end
    end

    assign launch = launch_q;

endmodule

// File: rtl/pong_frame_sequencer.sv
// Runs the four per-frame game update tasks in order during vertical blanking.
// Optional build macro SEQ_TIMEOUT_EN adds a WAIT-state timeout that forces progress.
//
//  state     | meaning
//  ST_IDLE   | no sequence running; waiting for launch with Enable high
//  ST_ISSUE  | TaskStart[idx] is high this cycle
//  ST_WAIT   | waiting for TaskDone[idx] (or timeout when enabled)
//  ST_FINISH | FrameUpdated pulse; FrameCount already incremented
module pong_frame_sequencer
    import pong_frame_sequencer_pkg::*;
#(
    parameter int ResolutionSize = 10,
    parameter int FrameDivSize   = 4,
    parameter int TimeoutCycles  = 1000,
    parameter int TimeoutSize    = 10
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [ResolutionSize-1:0] ypos,
    input  logic [ResolutionSize-1:0] Yresolution,
    input  logic                      Enable,
    input  logic [FrameDivSize-1:0]   FrameDiv,
    input  logic [3:0]                TaskDone,
    output logic [3:0]                TaskStart,
    output logic                      UpdateBusy,
    output logic                      FrameUpdated,
    output logic [7:0]                FrameCount,
    output logic                      Overrun
);

    if ((2 ** TimeoutSize) <= TimeoutCycles) begin : g_bad_timeout_width
        $error("TimeoutSize too narrow for TimeoutCycles");
    end

    logic       launch;
    logic       task_done;
    logic       advance;

    seq_state_e state_q, state_d;
    task_idx_t  idx_q, idx_d;
    logic [3:0] task_start_q, task_start_d;
    logic       busy_q, busy_d;
    logic       frame_updated_q, frame_updated_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       overrun_q, overrun_d;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [TimeoutSize-1:0] TimeoutLast = TimeoutSize'(TimeoutCycles - 1);
    logic [TimeoutSize-1:0] timeout_q, timeout_d;
`endif

    pong_frame_sequencer_vblank_detector #(
        .ResolutionSize (ResolutionSize),
        .FrameDivSize   (FrameDivSize)
    ) u_vblank (
        .clk         (Clock),
        .rst         (Reset),
        .ypos        (ypos),
        .yresolution (Yresolution),
        .frame_div   (FrameDiv),
        .launch      (launch)
    );

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        task_start_d    = '0;
        frame_updated_d = 1'b0;
        frame_count_d   = frame_count_q;
        overrun_d       = overrun_q;
        task_done       = TaskDone[idx_q];
        advance         = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        timeout_d       = timeout_q;
`endif

        // A launch arriving mid-sequence is dropped and flagged.
        if (launch && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (launch && Enable) begin
                    state_d      = ST_ISSUE;
                    idx_d        = TASK_PADDLE;
                    task_start_d = task_onehot(TASK_PADDLE);
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
                timeout_d = '0;
`endif
            end
            ST_WAIT: begin
                advance = task_done;
`ifdef SEQ_TIMEOUT_EN
                if (!task_done) begin
                    if (timeout_q == TimeoutLast) begin
                        advance   = 1'b1;
                        overrun_d = 1'b1;
                    end else begin
                        timeout_d = timeout_q + 1'b1;
                    end
                end
`endif
                if (advance) begin
                    if (idx_q == TASK_SCORE) begin
                        state_d         = ST_FINISH;
                        frame_updated_d = 1'b1;
                        frame_count_d   = frame_count_q + 8'd1;
                    end else begin
                        state_d      = ST_ISSUE;
                        idx_d        = idx_q + 2'd1;
                        task_start_d = task_onehot(idx_q + 2'd1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q         <= ST_IDLE;
            idx_q           <= TASK_PADDLE;
            task_start_q    <= '0;
            busy_q          <= 1'b0;
            frame_updated_q <= 1'b0;
            frame_count_q   <= '0;
            overrun_q       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            timeout_q       <= '0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            task_start_q    <= task_start_d;
            busy_q          <= busy_d;
            frame_updated_q <= frame_updated_d;
            frame_count_q   <= frame_count_d;
            overrun_q       <= overrun_d;
`ifdef SEQ_TIMEOUT_EN
            timeout_q       <= timeout_d;
`endif
        end
    end

    assign TaskStart    = task_start_q;
    assign UpdateBusy   = busy_q;
    assign FrameUpdated = frame_updated_q;
    assign FrameCount   = frame_count_q;
    assign Overrun      = overrun_q;

endmodule

// File: tb/tb_pong_frame_sequencer.sv
// Directed-vector bench for pong_frame_sequencer; expected values are hand-derived.
module tb_pong_frame_sequencer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [9:0] ypos;
    logic [9:0] Yresolution;
    logic       Enable;
    logic [3:0] FrameDiv;
    logic [3:0] TaskDone;
    logic [3:0] TaskStart;
    logic       UpdateBusy;
    logic       FrameUpdated;
    logic [7:0] FrameCount;
    logic       Overrun;

    logic       resp_en;
    logic [3:0] resp_done;
    logic [3:0] resp_pend;
    logic [3:0] hold_mask;
    logic [3:0] man_done;

    int n_vec = 0;
    int n_err = 0;
    int n_start0 = 0;
    int n_fu = 0;

    pong_frame_sequencer #(
        .ResolutionSize (10),
        .FrameDivSize   (4),
        .TimeoutCycles  (8),
        .TimeoutSize    (4)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .ypos         (ypos),
        .Yresolution  (Yresolution),
        .Enable       (Enable),
        .FrameDiv     (FrameDiv),
        .TaskDone     (TaskDone),
        .TaskStart    (TaskStart),
        .UpdateBusy   (UpdateBusy),
        .FrameUpdated (FrameUpdated),
        .FrameCount   (FrameCount),
        .Overrun      (Overrun)
    );

    always #5 Clock = ~Clock;

    assign TaskDone = resp_en ? resp_done : man_done;

    // Update-unit model: answers each start pulse with a done one cycle later.
    initial begin
        resp_pend = '0;
        resp_done = '0;
        forever begin
            @(posedge Clock);
            #1;
            resp_done = resp_pend & ~hold_mask;
            resp_pend = TaskStart;
        end
    end

    initial begin
        forever begin
            @(posedge Clock);
            #1;
            if (TaskStart[0]) n_start0++;
            if (FrameUpdated) n_fu++;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic blank_interval(input int on_cycles, input int off_cycles);
        ypos = 10'd4;
        repeat (on_cycles) tick();
        ypos = 10'd3;
        repeat (off_cycles) tick();
    endtask

    int exp_starts[6] = '{0, 0, 1, 1, 1, 2};

    initial begin
        Reset       = 1'b1;
        ypos        = 10'd0;
        Yresolution = 10'd4;
        Enable      = 1'b1;
        FrameDiv    = 4'd0;
        man_done    = 4'b0000;
        resp_en     = 1'b0;
        hold_mask   = 4'b0000;
        repeat (3) tick();
        check_val("rst_start", TaskStart, 4'b0000);
        check_val("rst_busy", UpdateBusy, 1'b0);
        check_val("rst_count", FrameCount, 8'd0);
        check_val("rst_overrun", Overrun, 1'b0);
        check_val("rst_fu", FrameUpdated, 1'b0);
        Reset = 1'b0;
        ypos  = 10'd3;
        repeat (3) tick();

        // Basic sequence with exact launch latency and back-to-back chaining.
        ypos = 10'd4;
        tick();
        check_val("t1_n1_start", TaskStart, 4'b0000);
        tick();
        check_val("t1_n2_start", TaskStart, 4'b0001);
        check_val("t1_busy", UpdateBusy, 1'b1);
        tick();
        check_val("t1_issue_one_cycle", TaskStart, 4'b0000);
        man_done = 4'b0001;
        tick();
        man_done = 4'b0000;
        check_val("t1_start_ball", TaskStart, 4'b0010);
        tick();
        man_done = 4'b0010;
        tick();
        man_done = 4'b0000;
        check_val("t1_start_collide", TaskStart, 4'b0100);
        tick();
        man_done = 4'b0100;
        tick();
        man_done = 4'b0000;
        check_val("t1_start_score", TaskStart, 4'b1000);
        tick();
        check_val("t1_fu_early", FrameUpdated, 1'b0);
        man_done = 4'b1000;
        tick();
        man_done = 4'b0000;
        check_val("t1_fu", FrameUpdated, 1'b1);
        check_val("t1_count", FrameCount, 8'd1);
        tick();
        check_val("t1_fu_clear", FrameUpdated, 1'b0);
        check_val("t1_idle", UpdateBusy, 1'b0);
        ypos = 10'd3;
        repeat (4) tick();
        check_val("t1_fu_total", n_fu, 1);

        // Frame divider of 2: launches on the 3rd and 6th blanking edges.
        resp_en  = 1'b1;
        FrameDiv = 4'd2;
        for (int i = 0; i < 6; i++) begin
            blank_interval(16, 4);
            check_val("t2_starts", n_start0, 1 + exp_starts[i]);
        end
        check_val("t2_count", FrameCount, 8'd3);
        check_val("t2_overrun", Overrun, 1'b0);

        // Task 1 stalls across the next blanking edge: overrun, launch dropped.
        FrameDiv  = 4'd0;
        hold_mask = 4'b0010;
        blank_interval(4, 1);
        ypos = 10'd4;
        tick();
        tick();
        check_val("t3_overrun", Overrun, 1'b1);
        check_val("t3_busy", UpdateBusy, 1'b1);
        resp_en  = 1'b0;
        man_done = 4'b0010;
        tick();
        man_done  = 4'b0000;
        hold_mask = 4'b0000;
        resp_en   = 1'b1;
        repeat (12) tick();
        ypos = 10'd3;
        repeat (3) tick();
        check_val("t3_count", FrameCount, 8'd4);
        check_val("t3_starts", n_start0, 4);
        check_val("t3_idle", UpdateBusy, 1'b0);
        check_val("t3_sticky", Overrun, 1'b1);

        // Done on the wrong bits is ignored; then reset mid-sequence.
        resp_en = 1'b0;
        ypos    = 10'd4;
        tick();
        tick();
        check_val("t4_start_paddle", TaskStart, 4'b0001);
        tick();
        man_done = 4'b0001;
        tick();
        man_done = 4'b0000;
        check_val("t4_start_ball", TaskStart, 4'b0010);
        tick();
        man_done = 4'b1101;
        repeat (3) begin
            tick();
            check_val("t4_no_advance", TaskStart, 4'b0000);
        end
        check_val("t4_still_busy", UpdateBusy, 1'b1);
        man_done = 4'b0010;
        tick();
        man_done = 4'b0000;
        check_val("t4_start_collide", TaskStart, 4'b0100);
        tick();
        Reset = 1'b1;
        ypos  = 10'd3;
        tick();
        check_val("t5_start", TaskStart, 4'b0000);
        check_val("t5_busy", UpdateBusy, 1'b0);
        check_val("t5_count", FrameCount, 8'd0);
        check_val("t5_overrun", Overrun, 1'b0);
        check_val("t5_fu", FrameUpdated, 1'b0);
        Reset = 1'b0;
        repeat (3) tick();

        // Enable low: blanking edge launches nothing.
        Enable = 1'b0;
        blank_interval(8, 4);
        check_val("en_starts", n_start0, 5);
        check_val("en_busy", UpdateBusy, 1'b0);
        check_val("en_overrun", Overrun, 1'b0);
        Enable = 1'b1;

        // Task 0 never completes.
        ypos = 10'd4;
        tick();
        tick();
        check_val("to_start", TaskStart, 4'b0001);
        repeat (8) tick();
        check_val("to_before_start", TaskStart, 4'b0000);
        check_val("to_before_overrun", Overrun, 1'b0);
        tick();
`ifdef SEQ_TIMEOUT_EN
        check_val("to_overrun", Overrun, 1'b1);
        check_val("to_advance", TaskStart, 4'b0010);
`else
        check_val("to_overrun", Overrun, 1'b0);
        check_val("to_hold", TaskStart, 4'b0000);
        repeat (20) tick();
        check_val("to_hold_long", TaskStart, 4'b0000);
        check_val("to_hold_busy", UpdateBusy, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
